// File: rtl/temp_setpoint_parser.sv
// Converts the hot-end and bed ASCII temperature fields of a decoded line into binary setpoints.
// Optional macro SETPOINT_CLAMP_EN: over-ceiling values load the ceiling instead of being rejected.
module temp_setpoint_parser #(
  parameter logic [9:0] HOT_MAX = 10'd300,
  parameter logic [9:0] BED_MAX = 10'd120
) (
  input  logic        i_Clock50MHz,
  input  logic        i_Reset,
  input  logic        i_LineComplete,
  input  logic [23:0] i_HotTempAscii,
  input  logic [23:0] i_BedTempAscii,
  output logic [9:0]  o_HotSetpoint,
  output logic [9:0]  o_BedSetpoint,
  output logic        o_SetpointValid,
  output logic [1:0]  o_ParseError,
  output logic        o_Busy
);

  localparam int unsigned TEMP_W    = 10;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_BYTES = 6;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned SNAP_W    = NUM_BYTES * BYTE_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t              r_State;
  state_t              w_NextState;
  logic                r_LinePrev;
  logic                r_Armed;
  logic [SNAP_W-1:0]   r_Snap;
  logic [CNT_W-1:0]    r_ByteCnt;
  logic [TEMP_W-1:0]   r_HotAcc;
  logic [TEMP_W-1:0]   r_BedAcc;
  logic                r_HotSeen;
  logic                r_BedSeen;
  logic                r_HotErr;
  logic                r_BedErr;

  logic [SNAP_W-1:0]   d_Snap;
  logic [CNT_W-1:0]    d_ByteCnt;
  logic [TEMP_W-1:0]   d_HotAcc;
  logic [TEMP_W-1:0]   d_BedAcc;
  logic                d_HotSeen;
  logic                d_BedSeen;
  logic                d_HotErr;
  logic                d_BedErr;
  logic [TEMP_W-1:0]   d_HotSetpoint;
  logic [TEMP_W-1:0]   d_BedSetpoint;
  logic                d_SetpointValid;
  logic [1:0]          d_ParseError;
  logic                d_Busy;

  logic                w_Start;
  logic [BYTE_W-1:0]   w_CurByte;
  logic [BYTE_W-1:0]   w_DigitByte;
  logic [TEMP_W-1:0]   w_DigitVal;
  logic                w_IsSkip;
  logic                w_IsDigit;
  logic                w_IsHot;
  logic [TEMP_W-1:0]   w_SelAcc;
  logic                w_SelSeen;
  logic                w_SelErr;
  logic [TEMP_W-1:0]   w_StepAcc;
  logic                w_StepSeen;
  logic                w_StepErr;
  logic                w_HotOver;
  logic                w_BedOver;
  logic                w_HotRej;
  logic                w_BedRej;
  logic [TEMP_W-1:0]   w_HotValue;
  logic [TEMP_W-1:0]   w_BedValue;
  logic                w_HotFail;
  logic                w_BedFail;
  logic                w_HotLoad;
  logic                w_BedLoad;

  // Armed only once the line flag has been seen low, so a level held across reset cannot start.
  assign w_Start = (r_State == IDLE) && !o_Busy && r_Armed && i_LineComplete && !r_LinePrev;

  assign w_CurByte   = r_Snap[SNAP_W-1 -: BYTE_W];
  assign w_DigitByte = w_CurByte - 8'h30;
  assign w_DigitVal  = {2'b00, w_DigitByte};
  assign w_IsSkip    = (w_CurByte == 8'h00) || (w_CurByte == 8'h20);
  assign w_IsDigit   = (w_CurByte >= 8'h30) && (w_CurByte <= 8'h39);
  assign w_IsHot     = (r_ByteCnt < 3'd3);

  assign w_SelAcc  = w_IsHot ? r_HotAcc  : r_BedAcc;
  assign w_SelSeen = w_IsHot ? r_HotSeen : r_BedSeen;
  assign w_SelErr  = w_IsHot ? r_HotErr  : r_BedErr;

  // One decimal digit step for whichever channel owns the current byte.
  always_comb begin
    w_StepAcc  = w_SelAcc;
    w_StepSeen = w_SelSeen;
    w_StepErr  = w_SelErr;
    if (!w_SelErr) begin
      if (w_IsSkip) begin
        w_StepErr = w_SelSeen;
      end else if (w_IsDigit) begin
        w_StepAcc  = (w_SelAcc << 3) + (w_SelAcc << 1) + w_DigitVal;
        w_StepSeen = 1'b1;
      end else begin
        w_StepErr = 1'b1;
      end
    end
  end

  assign w_HotOver = (r_HotAcc > HOT_MAX);
  assign w_BedOver = (r_BedAcc > BED_MAX);

`ifdef SETPOINT_CLAMP_EN
  assign w_HotValue = w_HotOver ? HOT_MAX : r_HotAcc;
  assign w_BedValue = w_BedOver ? BED_MAX : r_BedAcc;
  assign w_HotRej   = 1'b0;
  assign w_BedRej   = 1'b0;
`else
  assign w_HotValue = r_HotAcc;
  assign w_BedValue = r_BedAcc;
  assign w_HotRej   = w_HotOver;
  assign w_BedRej   = w_BedOver;
`endif

  assign w_HotFail = r_HotErr | (r_HotSeen & w_HotRej);
  assign w_BedFail = r_BedErr | (r_BedSeen & w_BedRej);
  assign w_HotLoad = r_HotSeen & ~w_HotFail;
  assign w_BedLoad = r_BedSeen & ~w_BedFail;

  // State register
  always_ff @(posedge i_Clock50MHz or posedge i_Reset) begin
    if (i_Reset) r_State <= IDLE;
    else         r_State <= w_NextState;
  end

  // Next-state logic
  always_comb begin
    w_NextState = r_State;
    case (r_State)
      IDLE:    if (w_Start) w_NextState = CONV;
      CONV:    if (r_ByteCnt == CNT_W'(NUM_BYTES - 1)) w_NextState = UPDATE;
      UPDATE:  w_NextState = IDLE;
      default: w_NextState = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    d_Snap          = r_Snap;
    d_ByteCnt       = r_ByteCnt;
    d_HotAcc        = r_HotAcc;
    d_BedAcc        = r_BedAcc;
    d_HotSeen       = r_HotSeen;
    d_BedSeen       = r_BedSeen;
    d_HotErr        = r_HotErr;
    d_BedErr        = r_BedErr;
    d_HotSetpoint   = o_HotSetpoint;
    d_BedSetpoint   = o_BedSetpoint;
    d_ParseError    = o_ParseError;
    d_SetpointValid = (r_State == UPDATE);
    d_Busy          = (w_NextState != IDLE) || (r_State == UPDATE);
    case (r_State)
      IDLE: begin
        if (w_Start) begin
          d_Snap    = {i_HotTempAscii, i_BedTempAscii};
          d_ByteCnt = '0;
          d_HotAcc  = '0;
          d_BedAcc  = '0;
          d_HotSeen = 1'b0;
          d_BedSeen = 1'b0;
          d_HotErr  = 1'b0;
          d_BedErr  = 1'b0;
        end
      end
      CONV: begin
        d_Snap    = r_Snap << BYTE_W;
        d_ByteCnt = r_ByteCnt + 3'd1;
        if (w_IsHot) begin
          d_HotAcc  = w_StepAcc;
          d_HotSeen = w_StepSeen;
          d_HotErr  = w_StepErr;
        end else begin
          d_BedAcc  = w_StepAcc;
          d_BedSeen = w_StepSeen;
          d_BedErr  = w_StepErr;
        end
      end
      UPDATE: begin
        if (w_HotLoad) d_HotSetpoint = w_HotValue;
        if (w_BedLoad) d_BedSetpoint = w_BedValue;
        d_ParseError = {w_BedFail, w_HotFail};
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_Clock50MHz or posedge i_Reset) begin
    if (i_Reset) begin
      r_LinePrev      <= 1'b0;
      r_Armed         <= 1'b0;
      r_Snap          <= '0;
      r_ByteCnt       <= '0;
      r_HotAcc        <= '0;
      r_BedAcc        <= '0;
      r_HotSeen       <= 1'b0;
      r_BedSeen       <= 1'b0;
      r_HotErr        <= 1'b0;
      r_BedErr        <= 1'b0;
      o_HotSetpoint   <= '0;
      o_BedSetpoint   <= '0;
      o_SetpointValid <= 1'b0;
      o_ParseError    <= '0;
      o_Busy          <= 1'b0;
    end else begin
      r_LinePrev      <= i_LineComplete;
      r_Armed         <= r_Armed | ~i_LineComplete;
      r_Snap          <= d_Snap;
      r_ByteCnt       <= d_ByteCnt;
      r_HotAcc        <= d_HotAcc;
      r_BedAcc        <= d_BedAcc;
      r_HotSeen       <= d_HotSeen;
      r_BedSeen       <= d_BedSeen;
      r_HotErr        <= d_HotErr;
      r_BedErr        <= d_BedErr;
      o_HotSetpoint   <= d_HotSetpoint;
      o_BedSetpoint   <= d_BedSetpoint;
      o_SetpointValid <= d_SetpointValid;
      o_ParseError    <= d_ParseError;
      o_Busy          <= d_Busy;
    end
  end

endmodule

// File: tb/tb_temp_setpoint_parser.sv
// Directed bench for temp_setpoint_parser; expectations follow SETPOINT_CLAMP_EN when defined.
module tb_temp_setpoint_parser;

  logic        clk;
  logic        rst;
  logic        line;
  logic [23:0] hot_ascii;
  logic [23:0] bed_ascii;
  logic [9:0]  o_HotSetpoint;
  logic [9:0]  o_BedSetpoint;
  logic        o_SetpointValid;
  logic [1:0]  o_ParseError;
  logic        o_Busy;

  int tests_run;
  int tests_failed;

`ifdef SETPOINT_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  temp_setpoint_parser dut (
    .i_Clock50MHz   (clk),
    .i_Reset        (rst),
    .i_LineComplete (line),
    .i_HotTempAscii (hot_ascii),
    .i_BedTempAscii (bed_ascii),
    .o_HotSetpoint  (o_HotSetpoint),
    .o_BedSetpoint  (o_BedSetpoint),
    .o_SetpointValid(o_SetpointValid),
    .o_ParseError   (o_ParseError),
    .o_Busy         (o_Busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Raises the line flag (edge E0 is the next posedge) and watches 16 edges; inputs are trashed after E0.
  task automatic run_conv(input logic [23:0] hot, input logic [23:0] bed, input int glitch_at,
                          output int first_k, output int npulse, output logic [2:0] busy_obs);
    first_k  = -1;
    npulse   = 0;
    busy_obs = 3'b000;
    @(negedge clk);
    hot_ascii = hot;
    bed_ascii = bed;
    line      = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      if (o_SetpointValid) begin
        npulse++;
        if (first_k < 0) first_k = k;
      end
      if (k == 0) busy_obs[0] = o_Busy;
      if (k == 7) busy_obs[1] = o_Busy;
      if (k == 8) busy_obs[2] = o_Busy;
      if (k == 0) begin
        hot_ascii = 24'h393939;
        bed_ascii = 24'h393939;
      end
      if (glitch_at > 1 && k == glitch_at - 2) line = 1'b0;
      if (glitch_at > 1 && k == glitch_at - 1) line = 1'b1;
    end
    line = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; line = 1'b0; hot_ascii = '0; bed_ascii = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (o_HotSetpoint !== 10'd0)  begin tests_failed++; $display("FAIL reset hot: got %0d want 0", o_HotSetpoint); end
    tests_run++; if (o_BedSetpoint !== 10'd0)  begin tests_failed++; $display("FAIL reset bed: got %0d want 0", o_BedSetpoint); end
    tests_run++; if (o_SetpointValid !== 1'b0) begin tests_failed++; $display("FAIL reset valid: got %b want 0", o_SetpointValid); end
    tests_run++; if (o_ParseError !== 2'b00)   begin tests_failed++; $display("FAIL reset err: got %b want 00", o_ParseError); end
    tests_run++; if (o_Busy !== 1'b0)          begin tests_failed++; $display("FAIL reset busy: got %b want 0", o_Busy); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_hot_basic;
    int fk, np; logic [2:0] bo;
    run_conv(24'h323030, 24'h000000, -1, fk, np, bo);
    tests_run++; if (o_HotSetpoint !== 10'd200) begin tests_failed++; $display("FAIL hot200 hot: got %0d want 200", o_HotSetpoint); end
    tests_run++; if (o_BedSetpoint !== 10'd0)   begin tests_failed++; $display("FAIL hot200 bed: got %0d want 0", o_BedSetpoint); end
    tests_run++; if (o_ParseError !== 2'b00)    begin tests_failed++; $display("FAIL hot200 err: got %b want 00", o_ParseError); end
    tests_run++; if (fk !== 7)                  begin tests_failed++; $display("FAIL hot200 latency: got %0d want 7", fk); end
    tests_run++; if (np !== 1)                  begin tests_failed++; $display("FAIL hot200 pulses: got %0d want 1", np); end
    tests_run++; if (bo !== 3'b011)             begin tests_failed++; $display("FAIL hot200 busy E0/E7/E8: got %b want 011", bo); end
  endtask

  task automatic test_bed_basic;
    int fk, np; logic [2:0] bo;
    run_conv(24'h000000, 24'h003630, -1, fk, np, bo);
    tests_run++; if (o_BedSetpoint !== 10'd60)  begin tests_failed++; $display("FAIL bed60 bed: got %0d want 60", o_BedSetpoint); end
    tests_run++; if (o_HotSetpoint !== 10'd200) begin tests_failed++; $display("FAIL bed60 hot: got %0d want 200", o_HotSetpoint); end
    tests_run++; if (o_ParseError !== 2'b00)    begin tests_failed++; $display("FAIL bed60 err: got %b want 00", o_ParseError); end
  endtask

  task automatic test_hot_range;
    int fk, np; logic [2:0] bo;
    logic [9:0] exp_hot; logic [1:0] exp_err;
    exp_hot = CLAMP ? 10'd300 : 10'd200;
    exp_err = CLAMP ? 2'b00 : 2'b01;
    run_conv(24'h333530, 24'h000000, -1, fk, np, bo);
    tests_run++; if (o_HotSetpoint !== exp_hot) begin tests_failed++; $display("FAIL hot350 hot: got %0d want %0d", o_HotSetpoint, exp_hot); end
    tests_run++; if (o_ParseError !== exp_err)  begin tests_failed++; $display("FAIL hot350 err: got %b want %b", o_ParseError, exp_err); end
    tests_run++; if (o_BedSetpoint !== 10'd60)  begin tests_failed++; $display("FAIL hot350 bed: got %0d want 60", o_BedSetpoint); end
    tests_run++; if (np !== 1)                  begin tests_failed++; $display("FAIL hot350 pulses: got %0d want 1", np); end
  endtask

  task automatic test_bed_format;
    int fk, np; logic [2:0] bo;
    logic [9:0] exp_hot;
    exp_hot = CLAMP ? 10'd300 : 10'd200;
    run_conv(24'h000000, 24'h312A35, -1, fk, np, bo);
    tests_run++; if (o_BedSetpoint !== 10'd60)  begin tests_failed++; $display("FAIL bedfmt bed: got %0d want 60", o_BedSetpoint); end
    tests_run++; if (o_HotSetpoint !== exp_hot) begin tests_failed++; $display("FAIL bedfmt hot: got %0d want %0d", o_HotSetpoint, exp_hot); end
    tests_run++; if (o_ParseError !== 2'b10)    begin tests_failed++; $display("FAIL bedfmt err: got %b want 10", o_ParseError); end
    tests_run++; if (fk !== 7 || np !== 1)      begin tests_failed++; $display("FAIL bedfmt pulse: got k=%0d n=%0d want k=7 n=1", fk, np); end
  endtask

  task automatic test_skip_after_digit;
    int fk, np; logic [2:0] bo;
    logic [9:0] exp_hot;
    exp_hot = CLAMP ? 10'd300 : 10'd200;
    run_conv(24'h322030, 24'h313230, -1, fk, np, bo);
    tests_run++; if (o_HotSetpoint !== exp_hot) begin tests_failed++; $display("FAIL gap hot: got %0d want %0d", o_HotSetpoint, exp_hot); end
    tests_run++; if (o_BedSetpoint !== 10'd120) begin tests_failed++; $display("FAIL gap bed120: got %0d want 120", o_BedSetpoint); end
    tests_run++; if (o_ParseError !== 2'b01)    begin tests_failed++; $display("FAIL gap err: got %b want 01", o_ParseError); end
  endtask

  task automatic test_ceiling_edges;
    int fk, np; logic [2:0] bo;
    logic [1:0] exp_err;
    exp_err = CLAMP ? 2'b00 : 2'b10;
    run_conv(24'h333030, 24'h313231, -1, fk, np, bo);
    tests_run++; if (o_HotSetpoint !== 10'd300) begin tests_failed++; $display("FAIL ceil hot300: got %0d want 300", o_HotSetpoint); end
    tests_run++; if (o_BedSetpoint !== 10'd120) begin tests_failed++; $display("FAIL ceil bed121: got %0d want 120", o_BedSetpoint); end
    tests_run++; if (o_ParseError !== exp_err)  begin tests_failed++; $display("FAIL ceil err: got %b want %b", o_ParseError, exp_err); end
  endtask

  task automatic test_back_to_back;
    int fk, np; logic [2:0] bo;
    run_conv(24'h203735, 24'h000000, 4, fk, np, bo);
    tests_run++; if (o_HotSetpoint !== 10'd75)  begin tests_failed++; $display("FAIL b2b hot: got %0d want 75", o_HotSetpoint); end
    tests_run++; if (o_ParseError !== 2'b00)    begin tests_failed++; $display("FAIL b2b err: got %b want 00", o_ParseError); end
    tests_run++; if (np !== 1)                  begin tests_failed++; $display("FAIL b2b pulses: got %0d want 1", np); end
    tests_run++; if (fk !== 7)                  begin tests_failed++; $display("FAIL b2b latency: got %0d want 7", fk); end
  endtask

  task automatic test_reset_mid;
    int fk, np; logic [2:0] bo;
    bit activity;
    @(negedge clk);
    hot_ascii = 24'h313233;
    bed_ascii = 24'h303435;
    line      = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests_run++; if (o_HotSetpoint !== 10'd0)  begin tests_failed++; $display("FAIL midrst hot: got %0d want 0", o_HotSetpoint); end
    tests_run++; if (o_BedSetpoint !== 10'd0)  begin tests_failed++; $display("FAIL midrst bed: got %0d want 0", o_BedSetpoint); end
    tests_run++; if (o_ParseError !== 2'b00)   begin tests_failed++; $display("FAIL midrst err: got %b want 00", o_ParseError); end
    tests_run++; if (o_Busy !== 1'b0)          begin tests_failed++; $display("FAIL midrst busy: got %b want 0", o_Busy); end
    @(negedge clk);
    rst = 1'b0;
    activity = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (o_SetpointValid || o_Busy) activity = 1'b1;
    end
    tests_run++; if (activity !== 1'b0) begin tests_failed++; $display("FAIL midrst held-line: got activity=%b want 0", activity); end
    line = 1'b0;
    repeat (2) @(posedge clk);
    run_conv(24'h313030, 24'h000000, -1, fk, np, bo);
    tests_run++; if (o_HotSetpoint !== 10'd100 || np !== 1) begin tests_failed++; $display("FAIL midrst recover: got hot=%0d n=%0d want hot=100 n=1", o_HotSetpoint, np); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_hot_basic();
    test_bed_basic();
    test_hot_range();
    test_bed_format();
    test_skip_after_digit();
    test_ceiling_edges();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/temp_setpoint_parser.md
TEMP_SETPOINT_PARSER -- requirements
Module: temp_setpoint_parser

Interface
REQ-001 SHALL have parameter HOT_MAX, default 10'd300, hot-end setpoint ceiling in degrees C.
REQ-002 SHALL have parameter BED_MAX, default 10'd120, bed setpoint ceiling in degrees C.
REQ-003 SHALL have port i_Clock50MHz  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_LineComplete  input  1  level from the line decoder, held high for about 100 cycles per line.
REQ-006 SHALL have port i_HotTempAscii  input  24  three ASCII bytes, most significant character in [23:16].
REQ-007 SHALL have port i_BedTempAscii  input  24  same format as i_HotTempAscii.
REQ-008 SHALL have port o_HotSetpoint  output  10  binary hot-end setpoint.
REQ-009 SHALL have port o_BedSetpoint  output  10  binary bed setpoint.
REQ-010 SHALL have port o_SetpointValid  output  1  one-cycle pulse marking a completed conversion.
REQ-011 SHALL have port o_ParseError  output  2  per-channel reject flags, bit0 hot, bit1 bed.
REQ-012 SHALL have port o_Busy  output  1  high while a conversion is in progress.

Function
REQ-013 SHALL register i_LineComplete into r_LinePrev and define start as i_LineComplete=1 with r_LinePrev=0 while in IDLE.
REQ-014 SHALL snapshot both ASCII inputs on the start edge (E0), so later input changes do not affect the conversion.
REQ-015 SHALL ignore a start edge that arrives while o_Busy=1, with no queuing.
REQ-016 SHALL use FSM states IDLE, CONV, UPDATE: IDLE to CONV on start, CONV to UPDATE after 6 cycles, UPDATE to IDLE after 1 cycle.
REQ-017 SHALL process one byte per CONV cycle (E1 to E6) in the order hot [23:16], [15:8], [7:0], then bed in the same order.
REQ-018 SHALL skip a byte of 8'h00 or 8'h20 only while no digit has yet been seen for that channel.
REQ-019 SHALL treat a byte of 8'h30 to 8'h39 as a digit and update the accumulator as acc = (acc<<3) + (acc<<1) + (byte - 8'h30).
REQ-020 SHALL keep the accumulator 10 bits wide, since the maximum value 999 fits.
REQ-021 SHALL mark a channel as a format error on any other byte, or on a skip byte that follows a digit.
REQ-022 SHALL treat a channel with no digits (all skip bytes) as empty: setpoint retained, no error.
REQ-023 SHALL, without SETPOINT_CLAMP_EN, mark a channel as a range error when its value exceeds HOT_MAX or BED_MAX.
REQ-024 SHALL, at UPDATE (E7), load each channel that is valid and non-empty and retain the others.
REQ-025 SHALL, at UPDATE (E7), set o_ParseError to this conversion's error bits, overwriting previous flags.
REQ-026 SHALL drive o_SetpointValid high for exactly the one cycle after E7 (latency 7 edges after E0), even if both channels fail.
REQ-027 SHALL drive o_Busy high from the cycle after E0 through the cycle after E7.

Reset
REQ-028 SHALL, on i_Reset assertion, immediately force o_HotSetpoint=0, o_BedSetpoint=0, o_SetpointValid=0, o_ParseError=0, o_Busy=0.
REQ-029 SHALL, on i_Reset assertion, also clear the FSM to IDLE, the accumulators, the snapshots and r_LinePrev.
REQ-030 SHALL abandon any conversion in progress when reset asserts mid-conversion, with no pulse afterwards.
REQ-031 SHALL, after reset release, require a fresh 0-to-1 transition of i_LineComplete to start (a level already high does not start).

Configuration
REQ-032 SHALL support macro SETPOINT_CLAMP_EN: when defined, an over-ceiling value loads HOT_MAX or BED_MAX and is not flagged.
REQ-033 SHALL, when SETPOINT_CLAMP_EN is undefined, reject an over-ceiling value per REQ-023.
REQ-034 SHALL keep format-error handling identical whether or not SETPOINT_CLAMP_EN is defined.

Verification
REQ-035 SHALL cover: hot "200" (24'h323030), bed 0, rising edge -> o_HotSetpoint=200, o_BedSetpoint unchanged, o_ParseError=00, pulse 7 edges after E0.
REQ-036 SHALL cover: bed 24'h003630 ("60") -> o_BedSetpoint=60, no error.
REQ-037 SHALL cover: hot "350", macro undefined -> hot retained, o_ParseError=01; macro defined -> o_HotSetpoint=300, o_ParseError=00.
REQ-038 SHALL cover: bed 24'h312A35 ("1*5") -> bed retained, o_ParseError=10, o_SetpointValid still pulses.
REQ-039 SHALL cover: i_Reset asserted at E3 mid-conversion -> all outputs 0, no pulse; i_LineComplete held high after release -> no conversion.
REQ-040 SHALL cover: second rising edge of i_LineComplete at E4 -> ignored, exactly one pulse.
